// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl
// Description : Hazard and stage-control unit for a 5-stage in-order pipeline
//               (IF/ID/EX/MEM/WB).
//
//               Each cycle the block takes exactly one of four actions, in
//               this priority order:
//                 1. freeze   (mem_busy)
//                 2. redirect (redirect)
//                 3. RAW stall
//                 4. normal advance
//
//               It tracks a small record per stage and produces these outputs:
//                 - stall, flush and bubble controls
//                 - the operand forwarding selects for EX
//                 - a saturating counter of RAW stall cycles
//
// Configuration:
//               FORWARDING_EN defined
//                 - Only a load-use pair causes a RAW stall.
//                 - EX operands take forwarded values from MEM or WB.
//               FORWARDING_EN undefined (default)
//                 - Any in-flight EX or MEM writer of a used ID source causes
//                   a RAW stall.
//                 - WB needs no stall: the register file writes before it is
//                   read.
//                 - Both forwarding selects are tied to 0.
//
// Ports       :
//   clk                   in   clock, all state on posedge
//   rst                   in   asynchronous reset, active low
//   fetch_valid           in   instruction entering IF/ID this cycle
//   id_rs1 / id_rs2       in   source registers of the ID instruction
//   id_rs1_used/_rs2_used in   source operand actually read
//   id_rd                 in   destination register of the ID instruction
//   id_reg_write          in   ID instruction writes id_rd
//   id_mem_read           in   ID instruction is a load
//   redirect              in   taken branch/jump resolved in EX
//   mem_busy              in   memory stage not ready, whole pipe frozen
//   stall_if / stall_id   out  hold PC / hold IF/ID register
//   flush_id              out  squash IF/ID contents
//   bubble_ex             out  insert a NOP into EX
//   ex_valid, mem_valid,
//   wb_valid              out  stage valid bits
//   fwd_a_sel / fwd_b_sel out  0 regfile, 1 MEM result, 2 WB result
//   hazard_count          out  number of RAW stall cycles, saturating
//
// Revision    : 1.0  initial release
// ============================================================================
module pipeline_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  redirect,
    input  logic                  mem_busy,
    output logic                  stall_if,
    output logic                  stall_id,
    output logic                  flush_id,
    output logic                  bubble_ex,
    output logic                  ex_valid,
    output logic                  mem_valid,
    output logic                  wb_valid,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic [CNT_W-1:0]      hazard_count
);

    localparam logic [CNT_W-1:0]      c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [REG_ADDR_W-1:0] c_X0      = '0;

    // ------------------------------------------------------------------
    // Stage records
    // ------------------------------------------------------------------
    logic                  r_id_valid;

    logic                  r_ex_valid;
    logic [REG_ADDR_W-1:0] r_ex_rs1;
    logic [REG_ADDR_W-1:0] r_ex_rs2;
    logic                  r_ex_rs1_used;
    logic                  r_ex_rs2_used;
    logic [REG_ADDR_W-1:0] r_ex_rd;
    logic                  r_ex_reg_write;
    logic                  r_ex_mem_read;

    logic                  r_mem_valid;
    logic [REG_ADDR_W-1:0] r_mem_rd;
    logic                  r_mem_reg_write;
    logic                  r_mem_mem_read;

    logic                  r_wb_valid;
    logic [REG_ADDR_W-1:0] r_wb_rd;
    logic                  r_wb_reg_write;
    logic                  r_wb_mem_read;

    logic [CNT_W-1:0]      r_hazard_count;

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    logic w_id_hits_ex;
    logic w_id_hits_mem;
    logic w_raw_hazard;
    logic w_load_ex;
    logic w_unused_fields;

    // A producer hits the ID instruction only through a source that is
    // actually read. x0 is hard-wired, so it never creates a dependency.
    assign w_id_hits_ex  = (r_ex_rd != c_X0) &&
                           ((id_rs1_used && (id_rs1 == r_ex_rd)) ||
                            (id_rs2_used && (id_rs2 == r_ex_rd)));
    assign w_id_hits_mem = (r_mem_rd != c_X0) &&
                           ((id_rs1_used && (id_rs1 == r_mem_rd)) ||
                            (id_rs2_used && (id_rs2 == r_mem_rd)));

`ifdef FORWARDING_EN
    // Only a load in EX cannot forward in time to the dependent instruction.
    assign w_raw_hazard = r_id_valid && r_ex_valid && r_ex_mem_read && w_id_hits_ex;
    assign w_unused_fields = r_wb_mem_read;
`else
    assign w_raw_hazard = r_id_valid &&
                          ((r_ex_valid  && r_ex_reg_write  && w_id_hits_ex) ||
                           (r_mem_valid && r_mem_reg_write && w_id_hits_mem));
    // Operand and WB fields are tracked but not consumed without forwarding.
    assign w_unused_fields = ^{r_ex_rs1, r_ex_rs2, r_ex_rs1_used, r_ex_rs2_used,
                               r_wb_rd, r_wb_reg_write, r_wb_mem_read};
`endif

    // ID moves into EX only on a normal advance with a valid instruction.
    assign w_load_ex = r_id_valid && !redirect && !w_raw_hazard;

    // ------------------------------------------------------------------
    // Pipeline control outputs
    // ------------------------------------------------------------------
    // Gating with rst keeps the input-driven controls at 0 while the
    // pipeline is held in reset.
    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        flush_id  = 1'b0;
        bubble_ex = 1'b0;
        if (rst) begin
            if (mem_busy) begin
                stall_if = 1'b1;
                stall_id = 1'b1;
            end else if (redirect) begin
                flush_id  = 1'b1;
                bubble_ex = 1'b1;
            end else if (w_raw_hazard) begin
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                bubble_ex = 1'b1;
            end
        end
    end

    // MEM takes priority over WB because it holds the younger value. A load
    // result is not yet available in MEM, so a load is only forwarded from WB.
    always_comb begin
        fwd_a_sel = 2'd0;
        fwd_b_sel = 2'd0;
`ifdef FORWARDING_EN
        if (rst && r_ex_valid && r_ex_rs1_used && (r_ex_rs1 != c_X0)) begin
            if (r_mem_valid && r_mem_reg_write && !r_mem_mem_read && (r_mem_rd == r_ex_rs1))
                fwd_a_sel = 2'd1;
            else if (r_wb_valid && r_wb_reg_write && (r_wb_rd == r_ex_rs1))
                fwd_a_sel = 2'd2;
        end
        if (rst && r_ex_valid && r_ex_rs2_used && (r_ex_rs2 != c_X0)) begin
            if (r_mem_valid && r_mem_reg_write && !r_mem_mem_read && (r_mem_rd == r_ex_rs2))
                fwd_b_sel = 2'd1;
            else if (r_wb_valid && r_wb_reg_write && (r_wb_rd == r_ex_rs2))
                fwd_b_sel = 2'd2;
        end
`endif
    end

    assign ex_valid     = r_ex_valid;
    assign mem_valid    = r_mem_valid;
    assign wb_valid     = r_wb_valid;
    assign hazard_count = r_hazard_count;

    // ------------------------------------------------------------------
    // Record update
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_id_valid      <= 1'b0;
            r_ex_valid      <= 1'b0;
            r_ex_rs1        <= '0;
            r_ex_rs2        <= '0;
            r_ex_rs1_used   <= 1'b0;
            r_ex_rs2_used   <= 1'b0;
            r_ex_rd         <= '0;
            r_ex_reg_write  <= 1'b0;
            r_ex_mem_read   <= 1'b0;
            r_mem_valid     <= 1'b0;
            r_mem_rd        <= '0;
            r_mem_reg_write <= 1'b0;
            r_mem_mem_read  <= 1'b0;
            r_wb_valid      <= 1'b0;
            r_wb_rd         <= '0;
            r_wb_reg_write  <= 1'b0;
            r_wb_mem_read   <= 1'b0;
            r_hazard_count  <= '0;
        end else if (!mem_busy) begin
            // Older instructions drain on every non-frozen cycle, whatever
            // happens at the front of the pipe.
            r_mem_valid     <= r_ex_valid;
            r_mem_rd        <= r_ex_rd;
            r_mem_reg_write <= r_ex_reg_write;
            r_mem_mem_read  <= r_ex_mem_read;
            r_wb_valid      <= r_mem_valid;
            r_wb_rd         <= r_mem_rd;
            r_wb_reg_write  <= r_mem_reg_write;
            r_wb_mem_read   <= r_mem_mem_read;

            // EX either takes the ID instruction or becomes a bubble
            // (redirect, RAW stall, or no valid instruction in ID).
            r_ex_valid      <= w_load_ex;
            r_ex_rs1        <= w_load_ex ? id_rs1 : c_X0;
            r_ex_rs2        <= w_load_ex ? id_rs2 : c_X0;
            r_ex_rs1_used   <= w_load_ex && id_rs1_used;
            r_ex_rs2_used   <= w_load_ex && id_rs2_used;
            r_ex_rd         <= w_load_ex ? id_rd : c_X0;
            r_ex_reg_write  <= w_load_ex && id_reg_write;
            r_ex_mem_read   <= w_load_ex && id_mem_read;

            if (redirect) begin
                r_id_valid <= 1'b0;
            end else if (w_raw_hazard) begin
                // ID holds its instruction. The stall is counted up to
                // all-ones and then stays there.
                if (r_hazard_count != {CNT_W{1'b1}})
                    r_hazard_count <= r_hazard_count + c_CNT_ONE;
            end else begin
                r_id_valid <= fetch_valid;
            end
        end
    end

endmodule
`default_nettype wire
